// File: rtl/drm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drm_pkg
// Brief    : Shared constants for the data rate monitor: default counter and
//            window-timer widths, channel-count limit and the total-counter
//            wrap/saturate mode encoding.
// Revision : 1.0 - initial release
// ============================================================================
package drm_pkg;

    localparam int c_num_ch_default = 2;
    localparam int c_num_ch_max     = 8;
    localparam int c_cnt_w_default  = 32;
    localparam int c_win_w_default  = 24;

    // sat_mode encoding for the running totals
    localparam logic c_mode_wrap = 1'b0;
    localparam logic c_mode_sat  = 1'b1;

endpackage : drm_pkg
`default_nettype wire

// File: rtl/drm_chan_cnt.sv
`default_nettype none
// ============================================================================
// Module   : drm_chan_cnt
// Brief    : One monitored channel: running beat total (wrap or saturate,
//            sticky overflow), saturating window accumulator and the
//            last-completed-window rate register.
// Revision : 1.0 - initial release
// ============================================================================
module drm_chan_cnt
    import drm_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_beat,
    input  logic             i_sat_mode,
    input  logic             i_win_en,
    input  logic             i_terminal,
    output logic [CNT_W-1:0] o_total,
    output logic [CNT_W-1:0] o_rate,
    output logic [CNT_W-1:0] o_rate_next,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_rate;
    logic             r_ovf;
    logic [CNT_W-1:0] w_acc_sum;

    // Accumulator plus this cycle's beat, pinned at all-ones
    assign w_acc_sum = (i_beat && !(&r_acc)) ? r_acc + CNT_W'(1) : r_acc;

    // Running total: a beat at all-ones wraps or holds by mode, and always flags overflow
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_total <= '0;
            r_ovf   <= 1'b0;
        end else if (i_beat) begin
            if (&r_total) begin
                r_ovf <= 1'b1;
                if (i_sat_mode != c_mode_sat) begin
                    r_total <= '0;
                end
            end else begin
                r_total <= r_total + CNT_W'(1);
            end
        end
    end

    // Window accumulator; on the terminal cycle its final value moves to the rate register
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc  <= '0;
            r_rate <= '0;
        end else if (!i_win_en) begin
            r_acc <= '0;
        end else if (i_terminal) begin
            r_rate <= w_acc_sum;
            r_acc  <= '0;
        end else begin
            r_acc <= w_acc_sum;
        end
    end

    assign o_total     = r_total;
    assign o_rate      = r_rate;
    assign o_rate_next = w_acc_sum;
    assign o_ovf       = r_ovf;

endmodule : drm_chan_cnt
`default_nettype wire

// File: rtl/data_rate_monitor.sv
`default_nettype none
// ============================================================================
// Module   : data_rate_monitor
// Brief    : Per-channel valid/ready beat monitor with running totals, a
//            programmable measurement window producing per-window rates, and
//            an optional channel-0/1 rate mismatch detector.
// Config   : DATA_RATE_MONITOR_MISMATCH_EN - build the mismatch comparator;
//            without it mismatch is tied low and mis_thresh is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module data_rate_monitor
    import drm_pkg::*;
#(
    parameter int NUM_CH = c_num_ch_default,
    parameter int CNT_W  = c_cnt_w_default,
    parameter int WIN_W  = c_win_w_default
) (
    input  logic                    plf_clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH-1:0]       ch_ready,
    input  logic                    cnt_clr,
    input  logic                    sat_mode,
    input  logic [WIN_W-1:0]        win_len,
    input  logic [CNT_W-1:0]        mis_thresh,
    output logic [NUM_CH*CNT_W-1:0] total_cnt,
    output logic [NUM_CH*CNT_W-1:0] rate_cnt,
    output logic                    rate_vld,
    output logic [NUM_CH-1:0]       ovf,
    output logic                    mismatch
);

    generate
        if (NUM_CH < 1 || NUM_CH > c_num_ch_max) begin : g_bad_num_ch
            $error("data_rate_monitor: NUM_CH out of range 1..8");
        end
    endgenerate

    logic [WIN_W-1:0]        r_timer;
    logic                    r_rate_vld;
    logic                    w_win_en;
    logic                    w_terminal;
    logic [NUM_CH-1:0]       w_beat;
    logic [NUM_CH*CNT_W-1:0] w_rate_next;

    assign w_win_en = |win_len;
    // A window length shrunk to at or below the current count ends the window now
    assign w_terminal = w_win_en && (r_timer >= (win_len - WIN_W'(1)));
    assign w_beat     = ch_valid & ch_ready;

    // Window timer: free-runs 0..win_len-1, parked at 0 while windowing is off
    always_ff @(posedge plf_clk) begin
        if (rst || cnt_clr || !w_win_en || w_terminal) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + WIN_W'(1);
        end
    end

    // Rate-valid pulse follows the terminal cycle unless a clear wins
    always_ff @(posedge plf_clk) begin
        if (rst) begin
            r_rate_vld <= 1'b0;
        end else begin
            r_rate_vld <= w_terminal && !cnt_clr;
        end
    end

    assign rate_vld = r_rate_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            drm_chan_cnt #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk         (plf_clk),
                .rst         (rst),
                .i_clr       (cnt_clr),
                .i_beat      (w_beat[gi]),
                .i_sat_mode  (sat_mode),
                .i_win_en    (w_win_en),
                .i_terminal  (w_terminal),
                .o_total     (total_cnt[gi*CNT_W +: CNT_W]),
                .o_rate      (rate_cnt[gi*CNT_W +: CNT_W]),
                .o_rate_next (w_rate_next[gi*CNT_W +: CNT_W]),
                .o_ovf       (ovf[gi])
            );
        end
    endgenerate

`ifdef DATA_RATE_MONITOR_MISMATCH_EN
    generate
        if (NUM_CH < 2) begin : g_mis_bad_num_ch
            $error("data_rate_monitor: mismatch comparator needs NUM_CH >= 2");
        end
    endgenerate

    logic             r_mismatch;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W:0]   w_abs_diff;

    // Compare the rates about to be published so the flag lines up with rate_vld
    assign w_diff     = {1'b0, w_rate_next[0 +: CNT_W]} - {1'b0, w_rate_next[CNT_W +: CNT_W]};
    assign w_abs_diff = w_diff[CNT_W] ? (~w_diff + (CNT_W+1)'(1)) : w_diff;

    // Sticky mismatch flag, evaluated once per completed window
    always_ff @(posedge plf_clk) begin
        if (rst || cnt_clr) begin
            r_mismatch <= 1'b0;
        end else if (w_terminal && (w_abs_diff > {1'b0, mis_thresh})) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_mis;
    assign w_unused_mis = ^{mis_thresh, w_rate_next};
    assign mismatch     = 1'b0;
`endif

endmodule : data_rate_monitor
`default_nettype wire

// File: tb/tb_data_rate_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_rate_monitor
// Brief    : Self-checking bench for data_rate_monitor (NUM_CH=2, CNT_W=8,
//            WIN_W=8) with a cycle-level behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_rate_monitor;

    localparam int NCH  = 2;
    localparam int CW   = 8;
    localparam int WW   = 8;
    localparam int CMAX = 255;
`ifdef DATA_RATE_MONITOR_MISMATCH_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam int VW = 2*NCH*CW + NCH + 2;

    logic              plf_clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH-1:0]    ch_ready = '0;
    logic              cnt_clr = 1'b0;
    logic              sat_mode = 1'b0;
    logic [WW-1:0]     win_len = '0;
    logic [CW-1:0]     mis_thresh = '0;
    logic [NCH*CW-1:0] total_cnt;
    logic [NCH*CW-1:0] rate_cnt;
    logic              rate_vld;
    logic [NCH-1:0]    ovf;
    logic              mismatch;

    data_rate_monitor #(
        .NUM_CH (NCH),
        .CNT_W  (CW),
        .WIN_W  (WW)
    ) dut (
        .plf_clk    (plf_clk),
        .rst        (rst),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .cnt_clr    (cnt_clr),
        .sat_mode   (sat_mode),
        .win_len    (win_len),
        .mis_thresh (mis_thresh),
        .total_cnt  (total_cnt),
        .rate_cnt   (rate_cnt),
        .rate_vld   (rate_vld),
        .ovf        (ovf),
        .mismatch   (mismatch)
    );

    always #5 plf_clk = ~plf_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, plain integers
    int       m_total[NCH];
    int       m_acc[NCH];
    int       m_rate[NCH];
    int       m_timer = 0;
    bit       m_vld = 1'b0;
    bit [NCH-1:0] m_ovf = '0;
    bit       m_mis = 1'b0;

    // Apply one clock with the current inputs, stepping the model alongside
    task automatic advance();
        bit win_en;
        bit term;
        int beat;
        int d;
        win_en = (win_len != 0);
        term   = win_en && (m_timer >= int'(win_len) - 1);
        if (rst || cnt_clr) begin
            for (int i = 0; i < NCH; i++) begin
                m_total[i] = 0;
                m_acc[i]   = 0;
                m_rate[i]  = 0;
            end
            m_timer = 0;
            m_vld   = 1'b0;
            m_ovf   = '0;
            m_mis   = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                beat = (ch_valid[i] && ch_ready[i]) ? 1 : 0;
                if (beat == 1) begin
                    if (m_total[i] == CMAX) begin
                        m_ovf[i] = 1'b1;
                        if (!sat_mode) m_total[i] = 0;
                    end else begin
                        m_total[i] = m_total[i] + 1;
                    end
                end
                if (!win_en) begin
                    m_acc[i] = 0;
                end else if (term) begin
                    m_rate[i] = (m_acc[i] + beat > CMAX) ? CMAX : m_acc[i] + beat;
                    m_acc[i]  = 0;
                end else begin
                    m_acc[i] = (m_acc[i] + beat > CMAX) ? CMAX : m_acc[i] + beat;
                end
            end
            d = m_rate[0] - m_rate[1];
            if (d < 0) d = -d;
            if (MIS_EN && term && d > int'(mis_thresh)) m_mis = 1'b1;
            m_vld   = term;
            m_timer = (!win_en || term) ? 0 : m_timer + 1;
        end
        @(posedge plf_clk);
        #1;
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [NCH*CW-1:0] t;
        logic [NCH*CW-1:0] r;
        for (int i = 0; i < NCH; i++) begin
            t[i*CW +: CW] = CW'(m_total[i]);
            r[i*CW +: CW] = CW'(m_rate[i]);
        end
        return {t, r, m_vld, m_ovf, m_mis};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ch_valid = '1;
        ch_ready = '1;
        advance();
        advance();
        n_vec++;
        if ({total_cnt, rate_cnt, rate_vld, ovf, mismatch} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", {total_cnt, rate_cnt, rate_vld, ovf, mismatch});
        end
        rst = 1'b0;
    endtask

    task automatic test_window_rates();
        int pulses = 0;
        win_len  = WW'(10);
        ch_ready = '1;
        ch_valid = '1;
        cnt_clr  = 1'b1;
        advance();
        cnt_clr = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            ch_valid = {1'(c % 2), 1'b1};
            advance();
            n_vec++;
            if ({total_cnt, rate_cnt, rate_vld, ovf, mismatch} !== model_vec()) begin
                n_err++;
                $display("FAIL window_model c=%0d: got %h want %h", c,
                         {total_cnt, rate_cnt, rate_vld, ovf, mismatch}, model_vec());
            end
            if (rate_vld === 1'b1) begin
                pulses++;
                n_vec++;
                if (rate_cnt !== {8'd5, 8'd10}) begin
                    n_err++;
                    $display("FAIL window_rates c=%0d: got %h want 050a", c, rate_cnt);
                end
            end
        end
        n_vec++;
        if (pulses != 4) begin
            n_err++;
            $display("FAIL window_pulses: got %0d want 4", pulses);
        end
    endtask

    task automatic test_overflow();
        win_len  = '0;
        ch_ready = '1;
        for (int m = 0; m < 2; m++) begin
            sat_mode = 1'(m);
            cnt_clr  = 1'b1;
            advance();
            cnt_clr  = 1'b0;
            ch_valid = 2'b01;
            for (int c = 0; c < 255; c++) advance();
            n_vec++;
            if (total_cnt[0 +: CW] !== 8'd255 || ovf[0] !== 1'b0) begin
                n_err++;
                $display("FAIL ovf_preload mode=%0d: got total %0d ovf %b want 255 0", m, total_cnt[0 +: CW], ovf[0]);
            end
            advance();
            n_vec++;
            if (total_cnt[0 +: CW] !== ((m == 1) ? 8'd255 : 8'd0) || ovf[0] !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_step mode=%0d: got total %0d ovf %b want %0d 1", m,
                         total_cnt[0 +: CW], ovf[0], (m == 1) ? 255 : 0);
            end
            advance();
            n_vec++;
            if (total_cnt[0 +: CW] !== ((m == 1) ? 8'd255 : 8'd1) || ovf !== 2'b01) begin
                n_err++;
                $display("FAIL ovf_after mode=%0d: got total %0d ovf %b want %0d 01", m,
                         total_cnt[0 +: CW], ovf, (m == 1) ? 255 : 1);
            end
        end
        ch_valid = '0;
        sat_mode = 1'b0;
    endtask

    task automatic test_clr_terminal();
        win_len  = WW'(5);
        ch_valid = '1;
        ch_ready = '1;
        cnt_clr  = 1'b1;
        advance();
        cnt_clr = 1'b0;
        for (int c = 0; c < 4; c++) advance();
        n_vec++;
        if (total_cnt !== {8'd4, 8'd4} || rate_vld !== 1'b0) begin
            n_err++;
            $display("FAIL clr_pre: got total %h vld %b want 0404 0", total_cnt, rate_vld);
        end
        cnt_clr = 1'b1;
        advance();
        cnt_clr = 1'b0;
        n_vec++;
        if ({total_cnt, rate_cnt, rate_vld, ovf, mismatch} !== '0) begin
            n_err++;
            $display("FAIL clr_terminal: got %h want 0", {total_cnt, rate_cnt, rate_vld, ovf, mismatch});
        end
        ch_valid = '0;
        advance();
        n_vec++;
        if (rate_vld !== 1'b0) begin
            n_err++;
            $display("FAIL clr_no_vld: got %b want 0", rate_vld);
        end
    endtask

    task automatic test_mismatch();
        win_len    = WW'(10);
        mis_thresh = CW'(3);
        ch_ready   = '1;
        for (int p = 0; p < 2; p++) begin
            cnt_clr = 1'b1;
            advance();
            cnt_clr = 1'b0;
            for (int c = 0; c < 10; c++) begin
                ch_valid = {(c < 6 + p), 1'b1};
                advance();
            end
            n_vec++;
            if (rate_cnt !== {CW'(6 + p), 8'd10} || mismatch !== ((p == 0) ? MIS_EN : 1'b0)) begin
                n_err++;
                $display("FAIL mismatch_win p=%0d: got rate %h mis %b want %0d/10 %b", p, rate_cnt,
                         mismatch, 6 + p, (p == 0) ? MIS_EN : 1'b0);
            end
            ch_valid = '0;
            for (int c = 0; c < 10; c++) advance();
            n_vec++;
            if (rate_cnt !== '0 || mismatch !== ((p == 0) ? MIS_EN : 1'b0)) begin
                n_err++;
                $display("FAIL mismatch_sticky p=%0d: got rate %h mis %b", p, rate_cnt, mismatch);
            end
        end
    endtask

    task automatic test_win_disable();
        int vlds = 0;
        win_len  = WW'(4);
        ch_valid = '1;
        ch_ready = '1;
        cnt_clr  = 1'b1;
        advance();
        cnt_clr = 1'b0;
        for (int c = 0; c < 4; c++) advance();
        win_len = '0;
        for (int c = 0; c < 100; c++) begin
            advance();
            if (rate_vld === 1'b1) vlds++;
        end
        n_vec++;
        if (total_cnt !== {8'd104, 8'd104} || rate_cnt !== {8'd4, 8'd4} || vlds != 0) begin
            n_err++;
            $display("FAIL win_disable: got total %h rate %h pulses %0d want 6868 0404 0",
                     total_cnt, rate_cnt, vlds);
        end
    endtask

    task automatic test_rst_mid();
        int k = 0;
        win_len  = WW'(8);
        ch_valid = '1;
        ch_ready = '1;
        cnt_clr  = 1'b1;
        advance();
        cnt_clr = 1'b0;
        for (int c = 0; c < 4; c++) advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        n_vec++;
        if ({total_cnt, rate_cnt, rate_vld, ovf, mismatch} !== '0) begin
            n_err++;
            $display("FAIL rst_mid: got %h want 0", {total_cnt, rate_cnt, rate_vld, ovf, mismatch});
        end
        while (k < 25) begin
            advance();
            k++;
            if (rate_vld === 1'b1) break;
        end
        n_vec++;
        if (k != 8 || rate_cnt !== {8'd8, 8'd8}) begin
            n_err++;
            $display("FAIL rst_first_vld: got %0d cycles rate %h want 8 0808", k, rate_cnt);
        end
    endtask

    task automatic test_random();
        cnt_clr = 1'b1;
        advance();
        cnt_clr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            ch_valid = NCH'($urandom);
            ch_ready = NCH'($urandom);
            cnt_clr  = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 49) == 0) sat_mode = ~sat_mode;
            if ($urandom_range(0, 29) == 0) begin
                win_len    = WW'($urandom_range(0, 12));
                mis_thresh = CW'($urandom_range(0, 4));
            end
            advance();
            n_vec++;
            if ({total_cnt, rate_cnt, rate_vld, ovf, mismatch} !== model_vec()) begin
                n_err++;
                $display("FAIL random c=%0d: got %h want %h", c,
                         {total_cnt, rate_cnt, rate_vld, ovf, mismatch}, model_vec());
            end
        end
        cnt_clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_total[i] = 0;
            m_acc[i]   = 0;
            m_rate[i]  = 0;
        end
        test_reset();
        test_window_rates();
        test_overflow();
        test_clr_terminal();
        test_mismatch();
        test_win_disable();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_data_rate_monitor
`default_nettype wire
